// File: rtl/s_axi_read_bank_if.sv
// AXI4-Lite read channel bundle (AR + R) between interconnect and register-space read slave.
// The master modport belongs to the interconnect side and the slave modport to s_axi_read_bank.
interface s_axi_read_bank_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
    logic                  S_AXI_ARVALID;
    logic                  S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0] S_AXI_RDATA;
    logic [1:0]            S_AXI_RRESP;
    logic                  S_AXI_RVALID;
    logic                  S_AXI_RREADY;

    modport master (
        output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/s_axi_read_bank.sv
// AXI4-Lite read slave decoding bank0 (control/status) and bank1 (per-slot descriptors).
// Optional bank1 wait timeout is compiled in with `define S_AXI_READ_TIMEOUT_EN.
module s_axi_read_bank #(
    parameter int ADDR_WIDTH        = 16,
    parameter int DATA_WIDTH        = 32,
    parameter int BANK0_NUM_REGS    = 6,
    parameter int BANK1_INDEX_WIDTH = 2,
    parameter int BANK1_NUM_FIELDS  = 6,
    parameter int TIMEOUT_CYCLES    = 64,
    parameter int ERRCNT_WIDTH      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    s_axi_read_bank_if.slave             s_axi,
    output logic [7:0]                   bank0_rd_sel,
    input  logic [DATA_WIDTH-1:0]        bank0_rd_data,
    output logic                         bank1_req,
    output logic [BANK1_INDEX_WIDTH-1:0] bank1_index,
    output logic [3:0]                   bank1_field,
    input  logic [DATA_WIDTH-1:0]        bank1_rdata,
    input  logic                         bank1_ready,
    output logic [ERRCNT_WIDTH-1:0]      rd_err_cnt
);

    typedef enum logic [1:0] {IDLE, DECODE, WAIT_B1, RESP} state_e;
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    localparam int              IDX_MSB        = BANK1_INDEX_WIDTH + 5;
    localparam logic [7:0]      B0_LIMIT       = 8'(BANK0_NUM_REGS);
    localparam logic [4:0]      B1_FIELD_LIMIT = 5'(BANK1_NUM_FIELDS);

    state_e                  state_q, state_d;
    logic [15:2]             addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    resp_e                   rresp_q, rresp_d;
    logic                    arready_q, arready_d;
    logic [ERRCNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                    b1_oob;
    logic                    tmo_expired;

    // Address byte lanes carry no information for word-aligned register reads.
    wire unused_araddr = ^s_axi.S_AXI_ARADDR;

    assign b1_oob = (|addr_q[13:IDX_MSB+1]) || ({1'b0, addr_q[5:2]} >= B1_FIELD_LIMIT);

`ifdef S_AXI_READ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    assign tmo_expired = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == DECODE) begin
            tmo_d = '0;
        end else if (state_q == WAIT_B1 && !tmo_expired) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`else
    localparam int UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;

    assign tmo_expired = 1'b0;
`endif

    // NOTE: every _d gets its hold value first, so no path through this block infers a latch.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (s_axi.S_AXI_ARVALID && arready_q) begin
                    addr_d  = s_axi.S_AXI_ARADDR[15:2];
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = RESP;
                rdata_d = '0;
                rresp_d = RESP_OKAY;
                unique case (addr_q[15:14])
                    2'b00: begin
                        if (addr_q[13:6] < B0_LIMIT) rdata_d = bank0_rd_data;
                        else                          rresp_d = RESP_SLVERR;
                    end
                    2'b01: begin
                        if (b1_oob) rresp_d = RESP_SLVERR;
                        else        state_d = WAIT_B1;
                    end
                    default: rresp_d = RESP_DECERR;
                endcase
            end
            WAIT_B1: begin
                if (bank1_ready) begin
                    rdata_d = bank1_rdata;
                    rresp_d = RESP_OKAY;
                    state_d = RESP;
                end else if (tmo_expired) begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (s_axi.S_AXI_RREADY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != RESP && state_d == RESP && rresp_d != RESP_OKAY && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end

        // Registered ready keeps ARREADY low during reset and free of any ARVALID path.
        arready_d = (state_d == IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            arready_q <= arready_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = (state_q == RESP);
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;

    assign bank0_rd_sel = addr_q[13:6];
    assign bank1_index  = addr_q[IDX_MSB:6];
    assign bank1_field  = addr_q[5:2];
    assign bank1_req    = (state_q == WAIT_B1);
    assign rd_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_s_axi_read_bank.sv
// Scoreboard bench for s_axi_read_bank: stimulus pushes expected R beats, a monitor pops on R handshakes.
// Directed reads cover bank0, bank1 with wait states, error/decode responses, R stalls and reset abort.
module tb_s_axi_read_bank;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  bank0_rd_sel;
    logic [31:0] bank0_rd_data;
    logic        bank1_req;
    logic [1:0]  bank1_index;
    logic [3:0]  bank1_field;
    logic [31:0] bank1_rdata;
    logic        bank1_ready;
    logic [15:0] rd_err_cnt;

    logic [31:0] b0_regs [0:7];
    exp_t        exp_q [$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;

    s_axi_read_bank_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) axi ();

    s_axi_read_bank #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_axi        (axi),
        .bank0_rd_sel (bank0_rd_sel),
        .bank0_rd_data(bank0_rd_data),
        .bank1_req    (bank1_req),
        .bank1_index  (bank1_index),
        .bank1_field  (bank1_field),
        .bank1_rdata  (bank1_rdata),
        .bank1_ready  (bank1_ready),
        .rd_err_cnt   (rd_err_cnt)
    );

    always #5 clk = ~clk;

    assign bank0_rd_data = b0_regs[bank0_rd_sel[2:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_r(input logic [31:0] data, input logic [1:0] resp);
        exp_q.push_back({data, resp});
    endtask

    // Called just after a rising edge; returns just after the AR handshake edge.
    task automatic ar_issue(input logic [15:0] addr);
        bit got = 0;
        axi.S_AXI_ARADDR  = addr;
        axi.S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (axi.S_AXI_ARREADY) begin
                got = 1;
                break;
            end
        end
        check("ar_accept", got, 1);
        @(posedge clk);
        #1;
        axi.S_AXI_ARVALID = 1'b0;
    endtask

    task automatic wait_rvalid(input int max_cycles, input string name);
        bit got = 0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (axi.S_AXI_RVALID) begin
                got = 1;
                break;
            end
        end
        check(name, got, 1);
    endtask

    task automatic err_read(input logic [15:0] addr, input logic [1:0] resp, input string name);
        expect_r(32'h0, resp);
        ar_issue(addr);
        @(negedge clk);
        check({name, "_req_decode"}, bank1_req, 0);
        @(negedge clk);
        check({name, "_rvalid"}, axi.S_AXI_RVALID, 1);
        check({name, "_req_resp"}, bank1_req, 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset && axi.S_AXI_RVALID && axi.S_AXI_RREADY) begin
            if (exp_q.size() == 0) begin
                check("r_unexpected", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_rdata", axi.S_AXI_RDATA, mon_e.data);
                check("sb_rresp", axi.S_AXI_RRESP, mon_e.resp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b0;
        axi.S_AXI_ARADDR  = '0;
        axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY  = 1'b1;
        bank1_ready       = 1'b0;
        bank1_rdata       = '0;
        for (int i = 0; i < 8; i++) b0_regs[i] = 32'h0000_BAD0 + i;
        b0_regs[0] = 32'h0000_0011;
        b0_regs[1] = 32'h0000_0005;
        b0_regs[2] = 32'hDEAD_BEEF;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_arready", axi.S_AXI_ARREADY, 0);
        check("rst_rvalid", axi.S_AXI_RVALID, 0);
        check("rst_rdata", axi.S_AXI_RDATA, 0);
        check("rst_rresp", axi.S_AXI_RRESP, 0);
        check("rst_b1_req", bank1_req, 0);
        check("rst_err_cnt", rd_err_cnt, 0);
        check("rst_b0_sel", bank0_rd_sel, 0);
        check("rst_b1_index", bank1_index, 0);
        check("rst_b1_field", bank1_field, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("idle_arready", axi.S_AXI_ARREADY, 1);

        // Bank0 read; a stray bank1_ready outside WAIT_B1 must not matter.
        bank1_ready = 1'b1;
        bank1_rdata = 32'hFFFF_0000;
        expect_r(32'h0000_0005, OKAY);
        ar_issue(16'h0040);
        @(negedge clk);
        check("b0_sel", bank0_rd_sel, 1);
        check("b0_rvalid_decode", axi.S_AXI_RVALID, 0);
        @(negedge clk);
        check("b0_rvalid_lat2", axi.S_AXI_RVALID, 1);
        check("b0_no_req", bank1_req, 0);
        @(posedge clk);
        #1;
        bank1_ready = 1'b0;
        check("b0_back_idle", axi.S_AXI_ARREADY, 1);

        // Bank1 slot 2 field 1, ready after three request cycles.
        expect_r(32'h000A_BCDE, OKAY);
        ar_issue(16'h4084);
        @(negedge clk);
        check("b1_req_decode", bank1_req, 0);
        check("b1_index", bank1_index, 2);
        check("b1_field", bank1_field, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b1_wait_req", bank1_req, 1);
            check("b1_wait_rvalid", axi.S_AXI_RVALID, 0);
        end
        @(posedge clk);
        #1;
        bank1_ready = 1'b1;
        bank1_rdata = 32'h000A_BCDE;
        @(negedge clk);
        check("b1_req_at_ready", bank1_req, 1);
        @(posedge clk);
        #1;
        bank1_ready = 1'b0;
        bank1_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("b1_rvalid", axi.S_AXI_RVALID, 1);
        check("b1_req_dropped", bank1_req, 0);
        @(posedge clk);
        #1;

        // Error and decode-error responses.
        err_read(16'h0180, SLVERR, "b0_sel6");
        err_read(16'h4018, SLVERR, "b1_field6");
        err_read(16'h8000, DECERR, "decerr_8000");
        check("err_cnt_3", rd_err_cnt, 3);
        err_read(16'h4100, SLVERR, "b1_upper_bits");
        err_read(16'hC03C, DECERR, "decerr_c03c");
        check("err_cnt_5", rd_err_cnt, 5);

        // R stall with ARVALID held; the second read waits for the first RREADY.
        axi.S_AXI_RREADY = 1'b0;
        expect_r(32'hDEAD_BEEF, OKAY);
        expect_r(32'h0000_0011, OKAY);
        axi.S_AXI_ARADDR  = 16'h0080;
        axi.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        check("stall_ar_ready", axi.S_AXI_ARREADY, 1);
        @(posedge clk);
        #1;
        axi.S_AXI_ARADDR = 16'h0000;
        wait_rvalid(4, "stall_rvalid_seen");
        b0_regs[2] = 32'h0;
        for (int i = 0; i < 5; i++) begin
            check("stall_rvalid", axi.S_AXI_RVALID, 1);
            check("stall_rdata", axi.S_AXI_RDATA, 32'hDEAD_BEEF);
            check("stall_rresp", axi.S_AXI_RRESP, OKAY);
            check("stall_no_ar", axi.S_AXI_ARREADY, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        axi.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("stall_ar_after", axi.S_AXI_ARREADY, 1);
        @(posedge clk);
        #1;
        axi.S_AXI_ARVALID = 1'b0;
        @(negedge clk);
        check("stall2_decode", axi.S_AXI_RVALID, 0);
        @(negedge clk);
        check("stall2_rvalid", axi.S_AXI_RVALID, 1);
        @(posedge clk);
        #1;

`ifdef S_AXI_READ_TIMEOUT_EN
        begin
            int  req_cycles = 0;
            bit  got = 0;
            expect_r(32'h0, SLVERR);
            ar_issue(16'h4000);
            @(negedge clk);
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (axi.S_AXI_RVALID) begin
                    got = 1;
                    break;
                end
                if (bank1_req) req_cycles++;
            end
            check("tmo_resp", got, 1);
            check("tmo_req_cycles", req_cycles, 8);
            check("tmo_req_low", bank1_req, 0);
            @(posedge clk);
            #1;
        end
`endif

        // Reset pulse while waiting on bank1: the aborted read produces no response.
        ar_issue(16'h4000);
        @(negedge clk);
        @(negedge clk);
        check("abort_req_up", bank1_req, 1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_rvalid", axi.S_AXI_RVALID, 0);
        check("abort_req", bank1_req, 0);
        check("abort_err_cnt", rd_err_cnt, 0);
        check("abort_arready", axi.S_AXI_ARREADY, 0);
        check("abort_b0_sel", bank0_rd_sel, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        expect_r(32'h0000_0005, OKAY);
        ar_issue(16'h0040);
        wait_rvalid(4, "post_rst_rvalid");
        @(posedge clk);
        #1;

        repeat (3) @(posedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
